store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer
//   Write-back store buffer between a CPU memory stage and a single-ported
//   data memory. Stores are queued in a circular FIFO and drained to memory
//   when the port is idle, or when a full buffer must make room. A flush
//   drains every entry before new requests are accepted. Loads always get
//   the memory port and see the youngest buffered store to the same word.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_valid       CPU request present this cycle
//   req_wr          1 = store, 0 = load (qualified by req_valid)
//   req_addr        byte address (bit 0 ignored for matching)
//   req_wdata       store data
//   flush           drain all entries before accepting more requests
//   req_ready       request accepted this cycle (0 stalls the CPU)
//   rd_data         load result, combinational; 0 when no load is accepted
//   empty           no valid entries
//   mem_addr        data-memory address
//   mem_data_in     data-memory write data
//   mem_enable      data-memory enable
//   mem_wr          data-memory write strobe
//   mem_data_out    data-memory read data (combinational)
//
// States
//   IDLE  | normal operation; drain on idle cycles or full-buffer stores
//   FLUSH | one entry drained per cycle, CPU requests stalled

module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  input  logic                  flush,
  output logic                  req_ready,
  output logic [15:0]           rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  output logic                  mem_enable,
  output logic                  mem_wr,
  input  logic [15:0]           mem_data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WA_W  = ADDR_WIDTH - 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q;
  logic [WA_W-1:0]    waddr_q [DEPTH];
  logic [15:0]        data_q  [DEPTH];

  logic               full;
  logic               flush_mode;
  logic               load_acc;
  logic               store_acc;
  logic               drain;
  logic               fwd_hit;
  logic [15:0]        fwd_data;
  logic [PTR_W-1:0]   fwd_idx;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign flush_mode = (state_q == FLUSH) || flush;

  // Requests are refused during reset, in FLUSH, and while a flush request
  // is waiting on a non-empty buffer.
  assign req_ready = !rst && (state_q == IDLE) && !(flush && !empty);
  assign load_acc  = req_valid && !req_wr && req_ready;
  assign store_acc = req_valid &&  req_wr && req_ready;

  // Loads own the memory port; otherwise drain the head when the CPU is
  // idle, when a full buffer needs room, or while flushing.
  assign drain = !rst && !empty && !load_acc &&
                 (!req_valid || (store_acc && full) || flush_mode);

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && valid_q[fwd_idx] &&
          (waddr_q[fwd_idx] == req_addr[ADDR_WIDTH-1:1])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    rd_data     = '0;
    if (load_acc) begin
      mem_enable = 1'b1;
      mem_addr   = req_addr;
      rd_data    = fwd_hit ? fwd_data : mem_data_out;
    end else if (drain) begin
      mem_enable  = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = {waddr_q[head_q], 1'b0};
      mem_data_in = data_q[head_q];
    end
  end

  always_comb begin
    count_d = count_q;
    if (store_acc && !drain) begin
      count_d = count_q + CNT_W'(1);
    end else if (drain && !store_acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Stay in (or enter) FLUSH only while something is left after this edge,
  // so the pop of the last entry returns straight to IDLE.
  always_comb begin
    state_d = IDLE;
    if (((state_q == FLUSH) || flush) && (count_d != '0)) begin
      state_d = FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // When full, tail == head: the set must follow the clear.
      if (store_acc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && store_acc) begin
      waddr_q[tail_q] <= req_addr[ADDR_WIDTH-1:1];
      data_q[tail_q]  <= req_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed bench for store_buffer (DEPTH=4, ADDR_WIDTH=16). Inputs change
//   1 time unit after a rising edge and outputs are sampled 1 unit later.

module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        flush;
  logic        req_ready;
  logic [15:0] rd_data;
  logic        empty;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_out;

  int errors = 0;
  int checks = 0;

  store_buffer #(.DEPTH(4), .ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .req_ready    (req_ready),
    .rd_data      (rd_data),
    .empty        (empty),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_enable   (mem_enable),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic fl, input logic [15:0] mdo);
    req_valid    = v;
    req_wr       = wr;
    req_addr     = a;
    req_wdata    = wd;
    flush        = fl;
    mem_data_out = mdo;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] wd);
    drive(1'b1, 1'b1, a, wd, 1'b0, 16'h0);
  endtask

  task automatic expect_write(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, "_wr"},   {31'd0, mem_wr}, 32'd1);
    chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, a});
    chk({tag, "_data"}, {16'd0, mem_data_in}, {16'd0, d});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0070, 16'hEEEE, 1'b0, 16'h0);
    @(posedge clk);
    #1;
    chk("rst_no_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("rst_empty",  {31'd0, empty}, 32'd1);
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_rd",     {16'd0, rd_data}, 32'd0);
    chk("rst_en",     {31'd0, mem_enable}, 32'd0);
    chk("rst_addr",   {16'd0, mem_addr}, 32'd0);
    chk("rst_din",    {16'd0, mem_data_in}, 32'd0);

    // store then load of the same word forwards from the buffer
    tick();
    store(16'h0010, 16'h1234);
    chk("s1_ready", {31'd0, req_ready}, 32'd1);
    chk("s1_wr",    {31'd0, mem_wr}, 32'd0);
    chk("s1_en",    {31'd0, mem_enable}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0, 16'hDEAD);
    chk("l1_rd",    {16'd0, rd_data}, 32'h1234);
    chk("l1_wr",    {31'd0, mem_wr}, 32'd0);
    chk("l1_en",    {31'd0, mem_enable}, 32'd1);
    chk("l1_addr",  {16'd0, mem_addr}, 32'h0011);
    chk("l1_empty", {31'd0, empty}, 32'd0);
    tick();
    idle();
    expect_write("d1", 16'h0010, 16'h1234);
    tick();
    chk("d1_empty", {31'd0, empty}, 32'd1);
    chk("d1_nowr",  {31'd0, mem_wr}, 32'd0);

    // youngest of two stores to the same word wins; both drain in order
    store(16'h0020, 16'hAAAA);
    tick();
    store(16'h0020, 16'hBBBB);
    tick();
    drive(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h1111);
    chk("l2_rd", {16'd0, rd_data}, 32'hBBBB);
    tick();
    idle();
    expect_write("d2a", 16'h0020, 16'hAAAA);
    tick();
    expect_write("d2b", 16'h0020, 16'hBBBB);
    tick();
    chk("d2_empty", {31'd0, empty}, 32'd1);

    // load miss reads memory and holds off the drain
    store(16'h0030, 16'h7777);
    tick();
    drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h5A5A);
    chk("l3_rd",   {16'd0, rd_data}, 32'h5A5A);
    chk("l3_en",   {31'd0, mem_enable}, 32'd1);
    chk("l3_wr",   {31'd0, mem_wr}, 32'd0);
    chk("l3_addr", {16'd0, mem_addr}, 32'h0040);
    tick();
    idle();
    expect_write("d3", 16'h0030, 16'h7777);
    tick();
    chk("d3_empty", {31'd0, empty}, 32'd1);

    // fill with stores interleaved with loads (no idle cycles), then store when full
    for (int i = 0; i < 4; i++) begin
      store(16'(2 * i), 16'h1000 + 16'(2 * i));
      chk("f_st_wr", {31'd0, mem_wr}, 32'd0);
      tick();
      drive(1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 16'hCAFE);
      chk("f_ld_rd", {16'd0, rd_data}, 32'hCAFE);
      chk("f_ld_wr", {31'd0, mem_wr}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0, 16'hCAFE);
    chk("f_fwd", {16'd0, rd_data}, 32'h1004);
    tick();
    store(16'h0008, 16'h1008);
    chk("f_full_ready", {31'd0, req_ready}, 32'd1);
    expect_write("f_full", 16'h0000, 16'h1000);
    tick();
    idle();
    for (int i = 1; i < 5; i++) begin
      expect_write("f_drain", 16'(2 * i), 16'h1000 + 16'(2 * i));
      tick();
    end
    chk("f_empty", {31'd0, empty}, 32'd1);

    // flush with three entries: three stalled cycles, FIFO-order writes
    store(16'h0050, 16'h5050);
    tick();
    store(16'h0052, 16'h5252);
    tick();
    store(16'h0054, 16'h5454);
    tick();
    drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 16'h3333);
    chk("fl0_ready", {31'd0, req_ready}, 32'd0);
    chk("fl0_rd",    {16'd0, rd_data}, 32'd0);
    expect_write("fl0", 16'h0050, 16'h5050);
    tick();
    drive(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h3333);
    chk("fl1_ready", {31'd0, req_ready}, 32'd0);
    chk("fl1_rd",    {16'd0, rd_data}, 32'd0);
    expect_write("fl1", 16'h0052, 16'h5252);
    tick();
    chk("fl2_ready", {31'd0, req_ready}, 32'd0);
    expect_write("fl2", 16'h0054, 16'h5454);
    tick();
    idle();
    chk("fl3_empty", {31'd0, empty}, 32'd1);
    chk("fl3_ready", {31'd0, req_ready}, 32'd1);
    chk("fl3_nowr",  {31'd0, mem_wr}, 32'd0);
    tick();

    // reset in the middle of a flush discards the remaining entries
    store(16'h0060, 16'h6060);
    tick();
    store(16'h0062, 16'h6262);
    tick();
    store(16'h0064, 16'h6464);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0);
    expect_write("rf0", 16'h0060, 16'h6060);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rf_rst_nowr", {31'd0, mem_wr}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rf_empty", {31'd0, empty}, 32'd1);
    chk("rf_nowr",  {31'd0, mem_wr}, 32'd0);
    chk("rf_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("rf_nowr2", {31'd0, mem_wr}, 32'd0);
    drive(1'b1, 1'b0, 16'h0062, 16'h0, 1'b0, 16'h9999);
    chk("rf_ld_rd", {16'd0, rd_data}, 32'h9999);
    chk("rf_ld_en", {31'd0, mem_enable}, 32'd1);
    tick();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
